// File: rtl/data_memory_hs.sv
// Clocked word-addressed data memory with a MemRead/MemWrite request and MemReady handshake, WAIT_STATES wait cycles, byte-lane writes and range errors.
// Define MEM_ALIGN_CHECK_EN to also reject misaligned addresses and illegal ByteEn patterns.
module data_memory_hs #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [ADDR_WIDTH-1:0]   Address,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  input  logic [DATA_WIDTH/8-1:0] ByteEn,
  output logic [DATA_WIDTH-1:0]   ReadData,
  output logic                    MemReady,
  output logic                    MemError
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int WIDX_W = ADDR_WIDTH - OFF_W;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDX_W-1:0] DEPTH_W   = WIDX_W'(DEPTH);
  localparam logic [3:0]        WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t                state;
  logic [3:0]            waitCnt;
  logic [ADDR_WIDTH-1:0] reqAddr;
  logic [DATA_WIDTH-1:0] reqData;
  logic [NB-1:0]         reqBe;
  logic                  reqRd;
  logic                  reqWr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [WIDX_W-1:0]     wordIdx;
  logic [IDX_W-1:0]      memIdx;
  logic                  outOfRange;
  logic                  misaligned;
  logic                  accessErr;
  logic                  memWe;
  logic [DATA_WIDTH-1:0] oldWord;
  logic [DATA_WIDTH-1:0] merged;

  function automatic logic [DATA_WIDTH-1:0] mergeBytes(
    input logic [DATA_WIDTH-1:0] oldW,
    input logic [DATA_WIDTH-1:0] newW,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] r;
    r = oldW;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[8*i +: 8] = newW[8*i +: 8];
    end
    return r;
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  // Legal lane groups: 1, 2 or 4 contiguous bytes starting on a multiple of their size.
  function automatic logic legalBe(input logic [NB-1:0] be);
    logic ok;
    ok = 1'b0;
    for (int g = 1; g <= 4; g = g * 2) begin
      for (int k = 0; k + g <= NB; k = k + g) begin
        if (be == NB'(((1 << g) - 1) << k)) ok = 1'b1;
      end
    end
    return ok;
  endfunction

  assign misaligned = ((reqAddr[OFF_W-1:0] != '0) && (&reqBe)) || !legalBe(reqBe);
`else
  logic unusedOffset;
  assign unusedOffset = ^reqAddr[OFF_W-1:0];
  assign misaligned   = 1'b0;
`endif

  assign wordIdx    = reqAddr[ADDR_WIDTH-1:OFF_W];
  assign memIdx     = wordIdx[IDX_W-1:0];
  assign outOfRange = (wordIdx >= DEPTH_W);
  assign accessErr  = outOfRange | misaligned;
  assign oldWord    = mem[memIdx];
  assign merged     = mergeBytes(oldWord, reqData, reqBe);
  // A reset coinciding with the ACCESS edge must suppress the write.
  assign memWe      = rst_n && (state == ACCESS) && reqWr && !accessErr;

  always_ff @(posedge clk) begin
    if (memWe) mem[memIdx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && (MemRead || MemWrite)) begin
      reqAddr <= Address;
      reqData <= WriteData;
      reqBe   <= ByteEn;
      reqRd   <= MemRead;
      reqWr   <= MemWrite;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      waitCnt  <= '0;
      ReadData <= '0;
      MemReady <= 1'b0;
      MemError <= 1'b0;
    end else begin
      MemReady <= 1'b0;
      MemError <= 1'b0;
      case (state)
        IDLE: begin
          if (MemRead || MemWrite) begin
            waitCnt <= '0;
            state   <= (WAIT_STATES > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          if (waitCnt == WAIT_LAST) state <= ACCESS;
          else                      waitCnt <= waitCnt + 4'd1;
        end
        ACCESS: begin
          MemReady <= 1'b1;
          MemError <= accessErr;
          if (accessErr)  ReadData <= '0;
          else if (reqRd) ReadData <= reqWr ? merged : oldWord;
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed bench for data_memory_hs: a word-array model predicts every response, and a per-cycle monitor checks the outputs.
module tb_data_memory_hs;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic [3:0]  ByteEn = '0;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemError;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  logic        rstAtEdge = 1'b0;
  int          respCyc = -1;
  logic [31:0] pendRd = '0;
  logic        pendErr = 1'b0;
  logic        pendUpd = 1'b0;
  logic [31:0] expRd = '0;
  logic        started = 1'b0;
  logic [31:0] model [int];

  data_memory_hs #(
    .DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ByteEn(ByteEn),
    .ReadData(ReadData), .MemReady(MemReady), .MemError(MemError)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rstAtEdge <= !rst_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: outputs are checked every cycle once the first reset has taken effect.
  initial begin
    forever begin
      @(negedge clk);
      if (rstAtEdge) begin
        started = 1'b1;
        expRd   = '0;
      end else if (cyc == respCyc && pendUpd) begin
        expRd = pendRd;
      end
      if (started) begin
        chk("MemReady", {31'b0, MemReady}, {31'b0, (!rstAtEdge && cyc == respCyc)});
        chk("MemError", {31'b0, MemError}, {31'b0, (!rstAtEdge && cyc == respCyc && pendErr)});
        chk("ReadData", ReadData, expRd);
      end
    end
  end

  // abortAfter > 0: pull rst_n low that many cycles after driving the request.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input int abortAfter,
                       output logic [31:0] rdOut, output int lat);
    int          idx;
    bit          err;
    bit          seen;
    int          t0;
    logic [31:0] w;
    @(negedge clk);
    idx = int'(addr >> 2);
    err = (idx >= 256);
    w   = model.exists(idx) ? model[idx] : 32'h0;
    if (wr && !err)
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    pendErr   = err;
    pendUpd   = rd || err;
    pendRd    = err ? 32'h0 : w;
    MemRead   = rd;
    MemWrite  = wr;
    Address   = addr;
    WriteData = wd;
    ByteEn    = be;
    t0        = cyc;
    rdOut     = '0;
    lat       = 0;
    if (abortAfter > 0) begin
      respCyc = -1;
      repeat (abortAfter) @(negedge clk);
      rst_n    = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      respCyc = cyc + WS + 2;
      seen    = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (MemReady === 1'b1) seen = 1'b1;
      end
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: no MemReady for addr %h, expected one within 50 cycles", addr);
      end
      if (wr && !err) model[idx] = w;
      lat   = cyc - t0 - 1;
      rdOut = ReadData;
    end
  endtask

  initial begin
    logic [31:0] r;
    int          l;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(0, 1, 32'h0C, 32'h12345678, 4'hF, 0, r, l);
    issue(1, 0, 32'h0C, 32'h0, 4'h0, 0, r, l);
    chk("read_latency", l, 2);
    chk("read_word3", r, 32'h12345678);

    issue(0, 1, 32'h0C, 32'hFFFFFFFF, 4'hF, 0, r, l);
    issue(0, 1, 32'h0C, 32'h55555540, 4'b0011, 0, r, l);
    chk("write_keeps_readdata", r, 32'h12345678);
    issue(1, 0, 32'h0C, 32'h0, 4'h0, 0, r, l);
    chk("byte_write_merge", r, 32'hFFFF5540);

    issue(1, 1, 32'h1C, 32'h55555540, 4'hF, 0, r, l);
    chk("rd_wr_same_resp", r, 32'h55555540);
    issue(0, 1, 32'h1C, 32'hABCD0000, 4'b1100, 0, r, l);
    issue(1, 0, 32'h1C, 32'h0, 4'h0, 0, r, l);
    chk("upper_half_write", r, 32'hABCD5540);

    issue(0, 1, 32'h000, 32'h0BADF00D, 4'hF, 0, r, l);
    issue(0, 1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 0, r, l);
    issue(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, r, l);
    chk("oor_write_readdata", r, 32'h0);
    issue(1, 0, 32'h000, 32'h0, 4'h0, 0, r, l);
    chk("oor_no_alias_word0", r, 32'h0BADF00D);
    issue(1, 0, 32'h3FC, 32'h0, 4'h0, 0, r, l);
    chk("last_word", r, 32'hA5A5A5A5);
    issue(1, 0, 32'h400, 32'h0, 4'h0, 0, r, l);
    chk("oor_read", r, 32'h0);
    issue(1, 0, 32'h80000000, 32'h0, 4'h0, 0, r, l);

    issue(0, 1, 32'h0C, 32'h00000000, 4'h0, 0, r, l);
    issue(1, 0, 32'h0C, 32'h0, 4'h0, 0, r, l);
    chk("be_zero_no_change", r, 32'hFFFF5540);

    issue(0, 1, 32'h08, 32'h11112222, 4'hF, 0, r, l);
    issue(0, 1, 32'h08, 32'hDEADBEEF, 4'hF, 1, r, l);
    issue(1, 0, 32'h08, 32'h0, 4'h0, 0, r, l);
    chk("reset_in_wait", r, 32'h11112222);
    issue(0, 1, 32'h08, 32'hDEADBEEF, 4'hF, WS + 1, r, l);
    issue(1, 0, 32'h08, 32'h0, 4'h0, 0, r, l);
    chk("reset_at_access", r, 32'h11112222);

    issue(0, 1, 32'h0D, 32'hCAFEF00D, 4'hF, 0, r, l);
    issue(1, 0, 32'h0C, 32'h0, 4'h0, 0, r, l);
    chk("offset_ignored", r, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
